// File: rtl/transport_layer_udp_rx.sv
// -----------------------------------------------------------------------------
// transport_layer_udp_rx
// UDP receive parser. It sits on the IP-payload word stream, captures the
// 8-byte UDP header, forwards the UDP data words to the application with byte
// enables, and ignores Ethernet padding. It verifies the UDP checksum (seeded
// with the folded pseudo-header sum) and reports the result with a
// done_o strobe at the end of each accepted datagram.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   dev_port_i               local UDP port that datagrams must target
//   rcv_op_st_i/rcv_op_i/rcv_op_end_i/rcv_data_i
//                            IP-payload word stream (first byte in [31:24])
//   rcv_data_len_i           IP payload length in bytes
//   prot_type_i              IP protocol field (17 = UDP)
//   pseudo_crc_sum_i         folded pseudo-header checksum sum
//   app_op_st/app_op/app_op_end/app_data/app_be
//                            UDP data word stream to the application
//   source_port_o, dest_port_o, udp_len_o, checksum_o
//                            captured header fields
//   done_o, crc_ok_o, len_err_o
//                            end-of-datagram strobe and its status
//   port_drop_o              pulse when a datagram targets another port
// -----------------------------------------------------------------------------
module transport_layer_udp_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dev_port_i,
    input  logic        rcv_op_st_i,
    input  logic        rcv_op_i,
    input  logic        rcv_op_end_i,
    input  logic [31:0] rcv_data_i,
    input  logic [15:0] rcv_data_len_i,
    input  logic [7:0]  prot_type_i,
    input  logic [15:0] pseudo_crc_sum_i,
    output logic        app_op_st,
    output logic        app_op,
    output logic        app_op_end,
    output logic [31:0] app_data,
    output logic [3:0]  app_be,
    output logic [15:0] source_port_o,
    output logic [15:0] dest_port_o,
    output logic [15:0] udp_len_o,
    output logic [15:0] checksum_o,
    output logic        done_o,
    output logic        crc_ok_o,
    output logic        len_err_o,
    output logic        port_drop_o
);

    localparam logic [7:0]  UDP_PROTO = 8'd17;
    localparam logic [15:0] HDR_BYTES = 16'd8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_DATA     = 3'd2,
        S_DROP     = 3'd3,
        S_WAIT_END = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_acc, w_acc_nxt;
    logic [15:0] r_rem, w_rem_nxt;
    logic        r_first, w_first_nxt;
    logic        r_len_bad, w_len_bad_nxt;

    logic        w_app_op_st_nxt, w_app_op_nxt, w_app_op_end_nxt;
    logic [31:0] w_app_data_nxt;
    logic [3:0]  w_app_be_nxt;
    logic [15:0] w_src_nxt, w_dst_nxt, w_udp_len_nxt, w_cksum_nxt;
    logic        w_done_nxt, w_crc_ok_nxt, w_len_err_nxt, w_port_drop_nxt;

    // Zero the bytes of a word that lie beyond the UDP length.
    function automatic logic [31:0] mask_tail(input logic [31:0] data, input logic [15:0] rem);
        logic [31:0] m;
        case (rem)
            16'd0:   m = 32'h0000_0000;
            16'd1:   m = 32'hFF00_0000;
            16'd2:   m = 32'hFFFF_0000;
            16'd3:   m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return data & m;
    endfunction

    // Byte enables for the final data word given the bytes still owed.
    function automatic logic [3:0] last_be(input logic [15:0] rem);
        logic [3:0] be;
        case (rem)
            16'd1:   be = 4'b1000;
            16'd2:   be = 4'b1100;
            16'd3:   be = 4'b1110;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] add_halves(input logic [31:0] acc, input logic [31:0] data);
        return acc + {16'h0000, data[31:16]} + {16'h0000, data[15:0]};
    endfunction

    // Two end-around-carry folds are enough to bring any 32-bit sum to 16 bits.
    function automatic logic crc_good(input logic [15:0] cksum, input logic [31:0] acc);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
        t2 = {16'h0000, t1[31:16]} + {16'h0000, t1[15:0]};
        return (cksum == 16'h0000) || (t2[15:0] == 16'hFFFF);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_acc_nxt        = r_acc;
        w_rem_nxt        = r_rem;
        w_first_nxt      = r_first;
        w_len_bad_nxt    = r_len_bad;
        w_app_op_st_nxt  = 1'b0;
        w_app_op_nxt     = 1'b0;
        w_app_op_end_nxt = 1'b0;
        w_app_data_nxt   = app_data;
        w_app_be_nxt     = app_be;
        w_src_nxt        = source_port_o;
        w_dst_nxt        = dest_port_o;
        w_udp_len_nxt    = udp_len_o;
        w_cksum_nxt      = checksum_o;
        w_done_nxt       = 1'b0;
        w_crc_ok_nxt     = crc_ok_o;
        w_len_err_nxt    = len_err_o;
        w_port_drop_nxt  = 1'b0;

        if (rcv_op_i && rcv_op_st_i) begin
            // A start word while a datagram is open aborts it; a dropped one ends silently.
            if ((r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WAIT_END)) begin
                w_done_nxt       = 1'b1;
                w_crc_ok_nxt     = 1'b0;
                w_len_err_nxt    = 1'b1;
                w_app_op_end_nxt = (r_state == S_DATA) && !r_first;
            end else begin
                w_done_nxt       = 1'b0;
            end
            if (prot_type_i == UDP_PROTO) begin
                w_src_nxt     = rcv_data_i[31:16];
                w_dst_nxt     = rcv_data_i[15:0];
                w_acc_nxt     = add_halves({16'h0000, pseudo_crc_sum_i}, rcv_data_i);
                w_rem_nxt     = 16'd0;
                w_first_nxt   = 1'b1;
                w_len_bad_nxt = 1'b0;
                if (rcv_op_end_i) begin
                    // Datagram shorter than its own header.
                    w_done_nxt    = 1'b1;
                    w_crc_ok_nxt  = 1'b0;
                    w_len_err_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_state_nxt   = S_HDR;
                end
            end else begin
                w_state_nxt = rcv_op_end_i ? S_IDLE : S_DROP;
            end
        end else if (rcv_op_i) begin
            case (r_state)
                S_HDR: begin
                    w_udp_len_nxt = rcv_data_i[31:16];
                    w_cksum_nxt   = rcv_data_i[15:0];
                    w_acc_nxt     = add_halves(r_acc, rcv_data_i);
                    if (dest_port_o != dev_port_i) begin
                        w_port_drop_nxt = 1'b1;
                        w_state_nxt     = rcv_op_end_i ? S_IDLE : S_DROP;
                    end else begin
                        if ((rcv_data_i[31:16] < HDR_BYTES) || (rcv_data_i[31:16] > rcv_data_len_i)) begin
                            w_len_bad_nxt = 1'b1;
                            w_rem_nxt     = 16'd0;
                            w_state_nxt   = S_WAIT_END;
                        end else begin
                            w_len_bad_nxt = 1'b0;
                            w_rem_nxt     = rcv_data_i[31:16] - HDR_BYTES;
                            w_state_nxt   = (rcv_data_i[31:16] == HDR_BYTES) ? S_WAIT_END : S_DATA;
                        end
                        if (rcv_op_end_i) begin
                            w_done_nxt    = 1'b1;
                            w_len_err_nxt = w_len_bad_nxt || (w_rem_nxt != 16'd0);
                            w_crc_ok_nxt  = crc_good(w_cksum_nxt, w_acc_nxt);
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_done_nxt    = 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    w_acc_nxt       = add_halves(r_acc, mask_tail(rcv_data_i, r_rem));
                    w_app_op_nxt    = 1'b1;
                    w_app_op_st_nxt = r_first;
                    w_app_data_nxt  = rcv_data_i;
                    w_first_nxt     = 1'b0;
                    if (r_rem <= 16'd4) begin
                        w_app_op_end_nxt = 1'b1;
                        w_app_be_nxt     = last_be(r_rem);
                        w_rem_nxt        = 16'd0;
                        w_state_nxt      = S_WAIT_END;
                    end else begin
                        // An early end still closes the burst on this word.
                        w_app_op_end_nxt = rcv_op_end_i;
                        w_app_be_nxt     = 4'b1111;
                        w_rem_nxt        = r_rem - 16'd4;
                        w_state_nxt      = S_DATA;
                    end
                    if (rcv_op_end_i) begin
                        w_done_nxt    = 1'b1;
                        w_len_err_nxt = r_len_bad || (w_rem_nxt != 16'd0);
                        w_crc_ok_nxt  = crc_good(w_cksum_nxt, w_acc_nxt);
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_done_nxt    = 1'b0;
                    end
                end
                S_WAIT_END: begin
                    // Padding words are neither output nor summed.
                    if (rcv_op_end_i) begin
                        w_done_nxt    = 1'b1;
                        w_len_err_nxt = r_len_bad;
                        w_crc_ok_nxt  = crc_good(checksum_o, r_acc);
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_state_nxt   = S_WAIT_END;
                    end
                end
                S_DROP: begin
                    w_state_nxt = rcv_op_end_i ? S_IDLE : S_DROP;
                end
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= 32'h0000_0000;
            r_rem         <= 16'd0;
            r_first       <= 1'b0;
            r_len_bad     <= 1'b0;
            app_op_st     <= 1'b0;
            app_op        <= 1'b0;
            app_op_end    <= 1'b0;
            app_data      <= 32'h0000_0000;
            app_be        <= 4'b0000;
            source_port_o <= 16'h0000;
            dest_port_o   <= 16'h0000;
            udp_len_o     <= 16'h0000;
            checksum_o    <= 16'h0000;
            done_o        <= 1'b0;
            crc_ok_o      <= 1'b0;
            len_err_o     <= 1'b0;
            port_drop_o   <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_rem         <= w_rem_nxt;
            r_first       <= w_first_nxt;
            r_len_bad     <= w_len_bad_nxt;
            app_op_st     <= w_app_op_st_nxt;
            app_op        <= w_app_op_nxt;
            app_op_end    <= w_app_op_end_nxt;
            app_data      <= w_app_data_nxt;
            app_be        <= w_app_be_nxt;
            source_port_o <= w_src_nxt;
            dest_port_o   <= w_dst_nxt;
            udp_len_o     <= w_udp_len_nxt;
            checksum_o    <= w_cksum_nxt;
            done_o        <= w_done_nxt;
            crc_ok_o      <= w_crc_ok_nxt;
            len_err_o     <= w_len_err_nxt;
            port_drop_o   <= w_port_drop_nxt;
        end
    end

endmodule

// File: tb/tb_transport_layer_udp_rx.sv
// -----------------------------------------------------------------------------
// tb_transport_layer_udp_rx
// Table of datagram records (inputs plus expected outputs) applied in a loop,
// once back-to-back and once with random idle gaps, plus hand-written abort
// and reset-mid-datagram sequences. Expected app words and done statuses are
// queued when stimulus is driven and checked by a monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_transport_layer_udp_rx;

    localparam logic [15:0] SRC = 16'h1234;
    localparam logic [15:0] DEV = 16'h0050;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dev_port_i;
    logic        rcv_op_st_i, rcv_op_i, rcv_op_end_i;
    logic [31:0] rcv_data_i;
    logic [15:0] rcv_data_len_i;
    logic [7:0]  prot_type_i;
    logic [15:0] pseudo_crc_sum_i;
    logic        app_op_st, app_op, app_op_end;
    logic [31:0] app_data;
    logic [3:0]  app_be;
    logic [15:0] source_port_o, dest_port_o, udp_len_o, checksum_o;
    logic        done_o, crc_ok_o, len_err_o, port_drop_o;

    transport_layer_udp_rx dut (
        .clk(clk), .rst(rst), .dev_port_i(dev_port_i),
        .rcv_op_st_i(rcv_op_st_i), .rcv_op_i(rcv_op_i), .rcv_op_end_i(rcv_op_end_i),
        .rcv_data_i(rcv_data_i), .rcv_data_len_i(rcv_data_len_i),
        .prot_type_i(prot_type_i), .pseudo_crc_sum_i(pseudo_crc_sum_i),
        .app_op_st(app_op_st), .app_op(app_op), .app_op_end(app_op_end),
        .app_data(app_data), .app_be(app_be),
        .source_port_o(source_port_o), .dest_port_o(dest_port_o),
        .udp_len_o(udp_len_o), .checksum_o(checksum_o),
        .done_o(done_o), .crc_ok_o(crc_ok_o), .len_err_o(len_err_o),
        .port_drop_o(port_drop_o)
    );

    always #5 clk = ~clk;

    // mode: 0 = checksum field 0, 1 = correct checksum, 2 = correct checksum then data bit flipped
    typedef struct {
        logic [7:0]       prot;
        logic [15:0]      dst;
        logic [15:0]      ulen;
        logic [15:0]      iplen;
        logic [15:0]      pseudo;
        int               mode;
        int               nwords;
        int               npad;
        logic [3:0][31:0] d;
        int               exp_napp;
        logic [3:0]       exp_be;
        logic             exp_done;
        logic             exp_crc;
        logic             exp_lenerr;
        logic             exp_drop;
    } case_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        st;
        logic        en;
    } app_exp_t;

    typedef struct packed {
        logic        crc;
        logic        lerr;
        logic        chk;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] cks;
    } done_exp_t;

    case_t     tbl [13];
    app_exp_t  app_q [$];
    done_exp_t done_q [$];
    app_exp_t  ea;
    done_exp_t ed;
    int n_checks = 0;
    int n_fail   = 0;
    int n_drop   = 0;
    int n_close  = 0;
    int exp_drop = 0;
    int exp_close = 0;
    bit gaps_en  = 1'b0;

    // Standard UDP checksum over pseudo sum, header (checksum field 0) and data within ulen.
    function automatic logic [15:0] cksum_of(input case_t c);
        logic [31:0] s;
        logic [31:0] w;
        int rem;
        int keep;
        s = {16'h0, c.pseudo} + {16'h0, SRC} + {16'h0, c.dst} + {16'h0, c.ulen};
        rem = int'(c.ulen) - 8;
        for (int i = 0; i < c.nwords; i++) begin
            w = c.d[i];
            keep = (rem >= 4) ? 4 : ((rem > 0) ? rem : 0);
            for (int b = keep; b < 4; b++) w[31-8*b -: 8] = 8'h00;
            s = s + {16'h0, w[31:16]} + {16'h0, w[15:0]};
            rem = rem - 4;
        end
        s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        s = {16'h0, s[31:16]} + {16'h0, s[15:0]};
        return ~s[15:0];
    endfunction

    task automatic drive_word(input logic [31:0] w, input logic st, input logic en,
                              input logic [7:0] prot, input logic [15:0] iplen, input logic [15:0] pseudo);
        if (gaps_en && ($urandom_range(0, 2) == 0)) begin
            rcv_op_i   = 1'b0;
            rcv_data_i = $urandom;
            @(posedge clk); #1;
        end
        rcv_op_i = 1'b1; rcv_op_st_i = st; rcv_op_end_i = en; rcv_data_i = w;
        prot_type_i = prot; rcv_data_len_i = iplen; pseudo_crc_sum_i = pseudo;
        @(posedge clk); #1;
        rcv_op_i = 1'b0; rcv_op_st_i = 1'b0; rcv_op_end_i = 1'b0;
    endtask

    task automatic send_case(input case_t c);
        logic [3:0][31:0] dd;
        logic [15:0] cks;
        logic [31:0] w;
        app_exp_t a;
        done_exp_t dn;
        int total;
        dd  = c.d;
        cks = (c.mode == 0) ? 16'h0000 : cksum_of(c);
        if (c.mode == 2) dd[0][16] = ~dd[0][16];
        for (int i = 0; i < c.exp_napp; i++) begin
            a.data = dd[i];
            a.be   = (i == c.exp_napp - 1) ? c.exp_be : 4'b1111;
            a.st   = (i == 0);
            a.en   = (i == c.exp_napp - 1);
            app_q.push_back(a);
        end
        if (c.exp_drop) exp_drop++;
        total = 2 + c.nwords + c.npad;
        for (int k = 0; k < total; k++) begin
            if (k == 0)                w = {SRC, c.dst};
            else if (k == 1)           w = {c.ulen, cks};
            else if (k < 2 + c.nwords) w = dd[k-2];
            else                       w = 32'hA5A5_A5A5;
            if ((k == total - 1) && c.exp_done) begin
                dn = '{c.exp_crc, c.exp_lenerr, 1'b1, SRC, c.dst, c.ulen, cks};
                done_q.push_back(dn);
            end
            drive_word(w, k == 0, k == total - 1, c.prot, c.iplen, c.pseudo);
        end
    endtask

    task automatic drain(input string nm);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ((app_q.size() != 0) || (done_q.size() != 0) || (n_drop != exp_drop) || (n_close != exp_close)) begin
            n_fail++;
            $display("FAIL drain_%s: pending app=%0d done=%0d drops=%0d closes=%0d, required 0 0 %0d %0d",
                     nm, app_q.size(), done_q.size(), n_drop, n_close, exp_drop, exp_close);
        end
        app_q.delete();
        done_q.delete();
        n_drop  = exp_drop;
        n_close = exp_close;
    endtask

    task automatic check_zero(input string nm);
        logic [185:0] v;
        v = {app_op_st, app_op, app_op_end, app_data, app_be, source_port_o, dest_port_o,
             udp_len_o, checksum_o, done_o, crc_ok_o, len_err_o, port_drop_o, 64'h0};
        n_checks++;
        if (v !== 186'h0) begin
            n_fail++;
            $display("FAIL %s: outputs=%h, required all zero", nm, v);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (app_op === 1'b1) begin
            n_checks++;
            if (app_q.size() == 0) begin
                n_fail++;
                $display("FAIL app_word: got data=%h be=%b st=%b end=%b, required no word",
                         app_data, app_be, app_op_st, app_op_end);
            end else begin
                ea = app_q.pop_front();
                if ({app_data, app_be, app_op_st, app_op_end} !== {ea.data, ea.be, ea.st, ea.en}) begin
                    n_fail++;
                    $display("FAIL app_word: got data=%h be=%b st=%b end=%b, required data=%h be=%b st=%b end=%b",
                             app_data, app_be, app_op_st, app_op_end, ea.data, ea.be, ea.st, ea.en);
                end
            end
        end
        if ((app_op_end === 1'b1) && (app_op !== 1'b1)) n_close++;
        if (done_o === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done: got done_o crc=%b lerr=%b, required no done", crc_ok_o, len_err_o);
            end else begin
                ed = done_q.pop_front();
                if ({crc_ok_o, len_err_o} !== {ed.crc, ed.lerr} ||
                    (ed.chk && ({source_port_o, dest_port_o, udp_len_o, checksum_o} !== {ed.src, ed.dst, ed.len, ed.cks}))) begin
                    n_fail++;
                    $display("FAIL done: got crc=%b lerr=%b hdr=%h %h %h %h, required crc=%b lerr=%b hdr=%h %h %h %h",
                             crc_ok_o, len_err_o, source_port_o, dest_port_o, udp_len_o, checksum_o,
                             ed.crc, ed.lerr, ed.src, ed.dst, ed.len, ed.cks);
                end
            end
        end
        if (port_drop_o === 1'b1) n_drop++;
    end

    initial begin
        app_exp_t  a;
        done_exp_t dn;
        //            prot   dst       ulen    iplen   pseudo    md nw np data                                                        napp be       done crc  lerr drop
        tbl[0]  = '{8'd17, 16'h0050, 16'd12, 16'd12, 16'h0000, 0, 1, 0, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},                     1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'd17, 16'h0050, 16'd13, 16'd13, 16'h1111, 1, 2, 2, {32'h0, 32'h0, 32'hEE000000, 32'hAABBCCDD},              2, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{8'd17, 16'h0050, 16'd16, 16'd20, 16'hC0DE, 1, 2, 0, {32'h0, 32'h0, 32'h05060708, 32'h01020304},              2, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{8'd17, 16'h0050, 16'd16, 16'd20, 16'hC0DE, 2, 2, 0, {32'h0, 32'h0, 32'h05060708, 32'h01020304},              2, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{8'd17, 16'h0051, 16'd12, 16'd12, 16'h0000, 0, 1, 0, {32'h0, 32'h0, 32'h0, 32'h12345678},                     0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{8'd6,  16'h0050, 16'd12, 16'd12, 16'h0000, 0, 1, 0, {32'h0, 32'h0, 32'h0, 32'h12345678},                     0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'd17, 16'h0050, 16'd5,  16'd16, 16'h0000, 0, 2, 0, {32'h0, 32'h0, 32'h22222222, 32'h11111111},              0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{8'd17, 16'h0050, 16'd20, 16'd20, 16'h0000, 0, 1, 0, {32'h0, 32'h0, 32'h0, 32'h0BADF00D},                     1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{8'd17, 16'h0050, 16'd8,  16'd8,  16'h0F0F, 1, 0, 1, {32'h0, 32'h0, 32'h0, 32'h0},                            0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'd17, 16'h0050, 16'd8,  16'd8,  16'h0F0F, 1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0},                            0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{8'd17, 16'h0050, 16'd14, 16'd14, 16'h7777, 1, 2, 0, {32'h0, 32'h0, 32'h12340000, 32'hCAFEBABE},              2, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{8'd17, 16'h0050, 16'd15, 16'd16, 16'h2468, 1, 2, 1, {32'h0, 32'h0, 32'h9ABCDE00, 32'h13579BDF},              2, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{8'd17, 16'h0050, 16'd30, 16'd20, 16'h0000, 0, 3, 0, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111},       0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; dev_port_i = DEV;
        rcv_op_st_i = 1'b0; rcv_op_i = 1'b0; rcv_op_end_i = 1'b0; rcv_data_i = 32'h0;
        rcv_data_len_i = 16'd0; prot_type_i = 8'd0; pseudo_crc_sum_i = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            gaps_en = (pass == 1);
            for (int i = 0; i < 13; i++) begin
                send_case(tbl[i]);
                drain($sformatf("p%0d_case%0d", pass, i));
            end
        end

        // Start word arriving mid-DATA aborts the open datagram.
        gaps_en = 1'b0;
        a = '{32'h11112222, 4'b1111, 1'b1, 1'b0};
        app_q.push_back(a);
        drive_word({SRC, DEV}, 1'b1, 1'b0, 8'd17, 16'd20, 16'h0000);
        drive_word({16'd20, 16'h0000}, 1'b0, 1'b0, 8'd17, 16'd20, 16'h0000);
        drive_word(32'h11112222, 1'b0, 1'b0, 8'd17, 16'd20, 16'h0000);
        dn = '{1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0};
        done_q.push_back(dn);
        exp_close++;
        send_case(tbl[0]);
        drain("abort_mid_data");

        // Reset in the middle of DATA, with a start word presented during reset.
        a = '{32'h33334444, 4'b1111, 1'b1, 1'b0};
        app_q.push_back(a);
        drive_word({SRC, DEV}, 1'b1, 1'b0, 8'd17, 16'd20, 16'h0000);
        drive_word({16'd20, 16'h0000}, 1'b0, 1'b0, 8'd17, 16'd20, 16'h0000);
        drive_word(32'h33334444, 1'b0, 1'b0, 8'd17, 16'd20, 16'h0000);
        rst = 1'b1; rcv_op_i = 1'b1; rcv_op_st_i = 1'b1; rcv_data_i = {SRC, DEV};
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid_data");
        @(posedge clk); #1;
        rst = 1'b0; rcv_op_i = 1'b0; rcv_op_st_i = 1'b0;
        send_case(tbl[1]);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/transport_layer_udp_rx.md
TRANSPORT_LAYER_UDP_RX -- requirements
Module: transport_layer_udp_rx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; port names clk and rst.
REQ-002 Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- dev_port_i  in  16  local UDP port
- rcv_op_st_i  in  1  first IP-payload word; coincident with rcv_op_i
- rcv_op_i  in  1  IP-payload word valid
- rcv_op_end_i  in  1  last IP-payload word; coincident with rcv_op_i
- rcv_data_i  in  32  payload word, first byte in [31:24]
- rcv_data_len_i  in  16  IP payload length, bytes
- prot_type_i  in  8  IP protocol field
- pseudo_crc_sum_i  in  16  folded pseudo-header sum
- app_op_st  out  1  first UDP data word
- app_op  out  1  UDP data word valid
- app_op_end  out  1  last UDP data word
- app_data  out  32  UDP data word
- app_be  out  4  byte enables, [3] = byte [31:24]
- source_port_o, dest_port_o, udp_len_o, checksum_o  out  16 each  captured header fields
- done_o  out  1  end-of-datagram status strobe
- crc_ok_o  out  1  checksum result, valid with done_o
- len_err_o  out  1  length error, valid with done_o
- port_drop_o  out  1  one-cycle pulse, datagram discarded

Function
REQ-003 SHALL implement FSM IDLE, HDR, DATA, DROP, WAIT_END.
REQ-004 IDLE: rcv_op_st_i&rcv_op_i with prot_type_i==17 SHALL capture source_port_o=data[31:16], dest_port_o=data[15:0] and go to HDR; with prot_type_i!=17, SHALL go to DROP with no outputs and no pulses.
REQ-005 HDR, on rcv_op_i: SHALL capture udp_len_o=data[31:16], checksum_o=data[15:0].
REQ-006 HDR: dest_port_o!=dev_port_i SHALL pulse port_drop_o and go to DROP.
REQ-007 HDR: udp_len<8 or udp_len>rcv_data_len_i SHALL set len_err, emit no app output and go to WAIT_END.
REQ-008 HDR otherwise SHALL set the remaining-byte counter to udp_len-8 and go to DATA, or to WAIT_END if udp_len==8.
REQ-009 DATA: each rcv_op_i word SHALL be output one cycle later on app_data with app_op=1; remaining decremented by 4, saturating at 0.
REQ-010 app_op_st SHALL coincide with the first data word; app_op_end with the word where remaining<=4; both may be set together.
REQ-011 app_be SHALL be 1111 except on the last word, where remaining = 1→1000, 2→1100, 3→1110, 4→1111.
REQ-012 After the last data word, the state SHALL be WAIT_END; Ethernet padding words SHALL be ignored and never output.
REQ-013 Checksum:
- 32-bit accumulator, seeded with pseudo_crc_sum_i at word 0
- adds both 16-bit halves of every word within udp_len, including header words
- bytes beyond udp_len masked to zero before adding
REQ-014 On rcv_op_end_i in HDR, DATA or WAIT_END, done_o SHALL pulse next cycle:
- crc_ok_o = (checksum_o==0) or (folded sum == 16'hFFFF), with the sum folded twice
- len_err_o = 1 if REQ-007 fired, or rcv_op_end_i arrived before remaining reached 0
- early end SHALL force app_op_end on that final word
- state returns to IDLE
REQ-015 DROP SHALL ignore words until rcv_op_end_i, then go to IDLE with no done_o.
REQ-016 rcv_op_st_i outside IDLE SHALL abort the current datagram:
- pulse done_o with len_err_o=1 and crc_ok_o=0
- then parse the new word as word 0
- any open app burst is closed with app_op_end on that pulse cycle, with app_op=0
REQ-017 Gaps (rcv_op_i=0) SHALL hold all state; outputs app_op, app_op_st, app_op_end, done_o and port_drop_o are single-cycle.

Reset
REQ-018 rst SHALL force IDLE and clear all outputs, counters and the accumulator to 0, overriding any in-progress datagram; the first rcv_op_st_i after release SHALL be accepted.

Verification
REQ-019 Port 0x1234→dev 0x0050, udp_len=12, checksum=0, data 0xDEADBEEF -> one app word DEADBEEF, be=1111, st=end=1; done_o with crc_ok=1, len_err=0.
REQ-020 udp_len=13, data words 0xAABBCCDD, 0xEE000000 plus 2 pad words -> app_be 1111 then 1000; no pad output; done_o after rcv_op_end_i.
REQ-021 Valid datagram with correct checksum, then the same with one bit flipped -> crc_ok_o=1, then 0.
REQ-022 dest port 0x0051 vs dev 0x0050 -> port_drop_o pulse, no app_op, no done_o; prot_type 6 -> nothing asserted.
REQ-023 udp_len=5 -> len_err_o=1; udp_len=20 with end after 3 words -> app_op_end on word 3, len_err_o=1.
REQ-024 rst mid-DATA, then a new datagram -> outputs 0 during rst; the new datagram is parsed correctly.
